// File: rtl/ks_datapath_if.sv
// Decode enum shared by the K&S datapath and its control unit, plus the bundle of
// control strobes, status outputs and RAM signals that connects the two.
package ks_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNZERO, I_BNNEG,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;

endpackage

interface ks_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    import ks_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in;
    logic [15:0]             instr_count;

    // The master is the control unit together with the RAM read port.
    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, data_in,
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out, instr_count
    );

    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, data_in,
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out, instr_count
    );

endinterface

// File: rtl/ks_datapath.sv
// K&S processor datapath: PC, IR, decoder, 4x16 register file, ALU and flags.
// Optional retired-instruction counter enabled by defining KS_INSTR_COUNT_EN.
module ks_datapath
    import ks_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    ks_datapath_if.slave bus
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_zero;
    logic              r_neg;
    logic              r_uovf;
    logic              r_sovf;

    decoded_instruction_type w_dec;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic [1:0]        w_sel_c;
    logic [1:0]        w_sel_mem;
    logic [1:0]        w_wr_sel;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_carry;
    logic              w_uovf;
    logic              w_sovf;
    logic              w_unused_ir7;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dec = I_NOP;
        case (r_ir[15:8])
            8'h00:   w_dec = I_NOP;
            8'h01:   w_dec = I_BRANCH;
            8'h02:   w_dec = I_BZERO;
            8'h03:   w_dec = I_BNEG;
            8'h04:   w_dec = I_BOV;
            8'h05:   w_dec = I_BNOV;
            8'h0A:   w_dec = I_BNZERO;
            8'h0B:   w_dec = I_BNNEG;
            8'h81:   w_dec = I_LOAD;
            8'h82:   w_dec = I_STORE;
            8'h91:   w_dec = I_MOVE;
            8'hA1:   w_dec = I_ADD;
            8'hA2:   w_dec = I_SUB;
            8'hA3:   w_dec = I_AND;
            8'hA4:   w_dec = I_OR;
            8'hFF:   w_dec = I_HALT;
            default: w_dec = I_NOP;
        endcase
    end

    // MOVE packs its destination where ALU ops keep operand A and uses one source for both operands.
    always_comb begin
        w_sel_c = r_ir[5:4];
        w_sel_a = r_ir[3:2];
        w_sel_b = r_ir[1:0];
        if (w_dec == I_MOVE) begin
            w_sel_c = r_ir[3:2];
            w_sel_a = r_ir[1:0];
        end
    end

    assign w_sel_mem    = r_ir[6:5];
    assign w_wr_sel     = (w_dec == I_LOAD) ? w_sel_mem : w_sel_c;
    assign w_a          = r_regs[w_sel_a];
    assign w_b          = r_regs[w_sel_b];
    assign w_wr_data    = bus.c_sel ? bus.data_in : w_alu;
    assign w_unused_ir7 = r_ir[7];

    // Bit DATA_W of the widened sum/difference is the carry out for add and the borrow for sub.
    always_comb begin
        w_carry = 1'b0;
        w_alu   = '0;
        w_uovf  = 1'b0;
        w_sovf  = 1'b0;
        case (bus.operation)
            2'b00: begin
                {w_carry, w_alu} = {1'b0, w_a} + {1'b0, w_b};
                w_uovf = w_carry;
                w_sovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_alu[DATA_W-1] != w_a[DATA_W-1]);
            end
            2'b01: w_alu = w_a & w_b;
            2'b10: w_alu = w_a | w_b;
            default: begin
                {w_carry, w_alu} = {1'b0, w_a} - {1'b0, w_b};
                w_uovf = w_carry;
                w_sovf = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_alu[DATA_W-1] != w_a[DATA_W-1]);
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_uovf <= 1'b0;
            r_sovf <= 1'b0;
            // NOTE: the register file is small and architecturally defined as zero after reset, so it is cleared like ordinary flops.
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            if (bus.pc_enable)
                r_pc <= bus.branch ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
            if (bus.ir_enable)
                r_ir <= bus.data_in;
            if (bus.write_reg_enable)
                r_regs[w_wr_sel] <= w_wr_data;
            if (bus.flags_reg_enable) begin
                r_zero <= (w_alu == '0);
                r_neg  <= w_alu[DATA_W-1];
                r_uovf <= w_uovf;
                r_sovf <= w_sovf;
            end
        end
    end

`ifdef KS_INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_instr_count <= '0;
        else if (bus.ir_enable)
            r_instr_count <= r_instr_count + 16'd1;
    end

    assign bus.instr_count = r_instr_count;
`else
    assign bus.instr_count = '0;
`endif

    assign bus.decoded_instruction = w_dec;
    assign bus.zero_op             = r_zero;
    assign bus.neg_op              = r_neg;
    assign bus.unsigned_overflow   = r_uovf;
    assign bus.signed_overflow     = r_sovf;
    assign bus.ram_addr            = bus.addr_sel ? r_ir[ADDR_W-1:0] : r_pc;
    assign bus.data_out            = r_regs[w_sel_mem];

endmodule

// File: tb/tb_ks_datapath.sv
// Self-checking bench for ks_datapath: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic reference model.
module tb_ks_datapath;
    import ks_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ks_datapath_if bus ();

    ks_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    logic [4:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_regs [4];
    logic        m_z, m_n, m_u, m_s;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic decoded_instruction_type decode(input logic [15:0] ir);
        case (ir[15:8])
            8'h01: return I_BRANCH;
            8'h02: return I_BZERO;
            8'h03: return I_BNEG;
            8'h04: return I_BOV;
            8'h05: return I_BNOV;
            8'h0A: return I_BNZERO;
            8'h0B: return I_BNNEG;
            8'h81: return I_LOAD;
            8'h82: return I_STORE;
            8'h91: return I_MOVE;
            8'hA1: return I_ADD;
            8'hA2: return I_SUB;
            8'hA3: return I_AND;
            8'hA4: return I_OR;
            8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    // Computes the post-edge model state from the current inputs, waits for the edge, then commits it.
    task automatic step();
        logic [4:0]  n_pc = m_pc;
        logic [15:0] n_ir = m_ir;
        logic [15:0] n_regs [4];
        logic        n_z = m_z, n_n = m_n, n_u = m_u, n_s = m_s;
        int          n_cnt = m_cnt;
        int          ai, bi, ci, wi, a, b, sa, sb, full, s, res;
        bit          uo, so;
        decoded_instruction_type d;
        for (int i = 0; i < 4; i++) n_regs[i] = m_regs[i];
        if (!rst_n) begin
            n_pc = '0; n_ir = '0; n_z = 0; n_n = 0; n_u = 0; n_s = 0; n_cnt = 0;
            for (int i = 0; i < 4; i++) n_regs[i] = '0;
        end else begin
            d  = decode(m_ir);
            bi = int'(m_ir[1:0]);
            ai = (d == I_MOVE) ? bi : int'(m_ir[3:2]);
            ci = (d == I_MOVE) ? int'(m_ir[3:2]) : int'(m_ir[5:4]);
            wi = (d == I_LOAD) ? int'(m_ir[6:5]) : ci;
            a  = int'(m_regs[ai]);
            b  = int'(m_regs[bi]);
            sa = int'($signed(m_regs[ai]));
            sb = int'($signed(m_regs[bi]));
            uo = 0; so = 0;
            case (bus.operation)
                2'd0: begin full = a + b; s = sa + sb; uo = full > 65535; so = (s > 32767) || (s < -32768); end
                2'd1: full = a & b;
                2'd2: full = a | b;
                default: begin full = a - b; s = sa - sb; uo = a < b; so = (s > 32767) || (s < -32768); end
            endcase
            res = full & 32'hFFFF;
            if (bus.pc_enable) n_pc = bus.branch ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
            if (bus.ir_enable) n_ir = bus.data_in;
            if (bus.write_reg_enable) n_regs[wi] = bus.c_sel ? bus.data_in : 16'(res);
            if (bus.flags_reg_enable) begin
                n_z = (res == 0); n_n = (res >= 32768); n_u = uo; n_s = so;
            end
`ifdef KS_INSTR_COUNT_EN
            if (bus.ir_enable) n_cnt = (m_cnt + 1) % 65536;
`endif
        end
        @(posedge clk);
        m_pc = n_pc; m_ir = n_ir; m_z = n_z; m_n = n_n; m_u = n_u; m_s = n_s; m_cnt = n_cnt;
        for (int i = 0; i < 4; i++) m_regs[i] = n_regs[i];
        #2;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_decode",   32'(bus.decoded_instruction), 32'(decode(m_ir)));
            check("cmp_ram_addr", 32'(bus.ram_addr), 32'(bus.addr_sel ? m_ir[4:0] : m_pc));
            check("cmp_data_out", 32'(bus.data_out), 32'(m_regs[m_ir[6:5]]));
            check("cmp_flags", {28'd0, bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow},
                  {28'd0, m_z, m_n, m_u, m_s});
            check("cmp_count",    32'(bus.instr_count), 32'(m_cnt));
        end
    end

    task automatic idle();
        rst_n = 1'b1;
        bus.branch = 0; bus.pc_enable = 0; bus.ir_enable = 0; bus.write_reg_enable = 0;
        bus.addr_sel = 0; bus.c_sel = 0; bus.operation = 2'd0; bus.flags_reg_enable = 0;
    endtask

    task automatic load_ir(input logic [15:0] v);
        idle(); bus.ir_enable = 1; bus.data_in = v; step(); idle();
    endtask

    task automatic load_reg(input logic [15:0] ir, input logic [15:0] v);
        load_ir(ir); bus.c_sel = 1; bus.write_reg_enable = 1; bus.data_in = v; step(); idle();
    endtask

    task automatic alu(input logic [15:0] ir, input logic [1:0] op);
        load_ir(ir); bus.operation = op; bus.write_reg_enable = 1; bus.flags_reg_enable = 1; step(); idle();
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp_zn_us);
        check(name, {28'd0, bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}, {28'd0, exp_zn_us});
    endtask

    logic [7:0] opcodes [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'h0B,
                                 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};

    initial begin
        m_pc = '0; m_ir = '0; m_z = 0; m_n = 0; m_u = 0; m_s = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;

        // Reset held two cycles with every strobe high.
        rst_n = 0; bus.data_in = 16'hFFFF; bus.operation = 2'd3;
        bus.branch = 1; bus.pc_enable = 1; bus.ir_enable = 1; bus.write_reg_enable = 1;
        bus.addr_sel = 1; bus.c_sel = 1; bus.flags_reg_enable = 1;
        step(); step();
        idle(); #1;
        cmp_en = 1'b1;
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_decode", 32'(bus.decoded_instruction), 32'(I_NOP));
        check_flags("rst_flags", 4'b0000);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);

        // PC increments to 31 and wraps to 0.
        bus.pc_enable = 1;
        for (int i = 0; i < 31; i++) step();
        check("pc_31", 32'(bus.ram_addr), 32'd31);
        step();
        check("pc_wrap", 32'(bus.ram_addr), 32'd0);
        idle();

        // ADD overflow: R1 = 0x7FFF + 0x0001.
        load_ir(16'h8145);
        bus.addr_sel = 1; #1;
        check("load_addr", 32'(bus.ram_addr), 32'd5);
        check("load_decode", 32'(bus.decoded_instruction), 32'(I_LOAD));
        idle();
        bus.c_sel = 1; bus.write_reg_enable = 1; bus.data_in = 16'h7FFF; step(); idle();
        load_reg(16'h8165, 16'h0001);
        load_ir(16'hA11B);
        check("add_decode", 32'(bus.decoded_instruction), 32'(I_ADD));
        bus.operation = 2'd0; bus.write_reg_enable = 1; bus.flags_reg_enable = 1; step(); idle();
        check_flags("add_flags", 4'b0101);
        load_ir(16'h8220);
        check("add_r1", 32'(bus.data_out), 32'h8000);
        check("model_add_r1", 32'(m_regs[1]), 32'h8000);

        // SUB borrow, then an exact-zero difference.
        load_reg(16'h8145, 16'h0003);
        load_reg(16'h8165, 16'h0005);
        alu(16'hA21B, 2'd3);
        check_flags("sub_flags", 4'b0110);
        load_ir(16'h8220);
        check("sub_r1", 32'(bus.data_out), 32'hFFFE);
        load_reg(16'h8145, 16'h0005);
        alu(16'hA21B, 2'd3);
        check_flags("sub_zero_flags", 4'b1000);

        // LOAD/STORE addressing and register read-out.
        load_reg(16'h8145, 16'h1234);
        load_ir(16'h8247);
        bus.addr_sel = 1; #1;
        check("store_decode", 32'(bus.decoded_instruction), 32'(I_STORE));
        check("store_data", 32'(bus.data_out), 32'h1234);
        check("store_addr", 32'(bus.ram_addr), 32'd7);
        idle();

        // Branch loads the IR address field; PC holds without pc_enable.
        load_ir(16'h0112);
        check("br_decode", 32'(bus.decoded_instruction), 32'(I_BRANCH));
        bus.pc_enable = 1; bus.branch = 1; step(); idle();
        check("br_pc", 32'(bus.ram_addr), 32'h12);
        bus.branch = 1; step(); idle();
        check("br_hold", 32'(bus.ram_addr), 32'h12);

        // Randomized traffic with occasional mid-instruction resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            bus.branch = 1'($urandom); bus.pc_enable = 1'($urandom); bus.ir_enable = 1'($urandom);
            bus.write_reg_enable = 1'($urandom); bus.addr_sel = 1'($urandom); bus.c_sel = 1'($urandom);
            bus.operation = 2'($urandom); bus.flags_reg_enable = 1'($urandom);
            bus.data_in = {($urandom_range(0, 7) == 0) ? 8'($urandom) : opcodes[$urandom_range(0, 15)], 8'($urandom)};
            step();
        end

        // Instruction counter wraps past 0xFFFF.
        idle(); rst_n = 0; step(); idle();
        bus.ir_enable = 1; bus.data_in = 16'h0000;
        for (int i = 0; i < 70000; i++) step();
        idle(); #1;
`ifdef KS_INSTR_COUNT_EN
        check("count_wrap", 32'(bus.instr_count), 32'd4464);
        check("model_count_wrap", 32'(m_cnt), 32'd4464);
`else
        check("count_tied", 32'(bus.instr_count), 32'd0);
`endif

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
